quad_pwm: RTL and testbench

QUAD_PWM -- requirements
Module: quad_pwm

---
 rtl/quad_pwm_pkg.sv | 13 +
 rtl/pwm_channel.sv | 33 +++
 rtl/quad_pwm.sv | 86 ++++++++
 tb/tb_quad_pwm.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/quad_pwm_pkg.sv
// Shared types and constants for the four-channel PWM generator.
package quad_pwm_pkg;

    localparam int CNT_W = 12;
    localparam int NCH   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: a duty shadow register plus a registered unsigned compare.
module pwm_channel
    import quad_pwm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_active,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [CNT_W-1:0] i_duty,
    output logic             o_pwm
);

    logic [CNT_W-1:0] r_shadow;
    logic             r_pwm;

    // NOTE: the shadow is a plain flop, not RAM, so it is reset; a known value
    // keeps the first compare after reset defined.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
            r_pwm    <= 1'b0;
        end else begin
            // NOTE: non-blocking so the compare sees the shadow from before this edge.
            if (i_load)
                r_shadow <= i_duty;
            r_pwm <= i_active && (i_cnt < r_shadow);
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/quad_pwm.sv
// Four-channel PWM with a shared period counter and an IDLE/RUN/DRAIN controller.
module quad_pwm
    import quad_pwm_pkg::*;
#(
    parameter int PERIOD = 4095
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] duty1,
    input  logic [CNT_W-1:0] duty2,
    input  logic [CNT_W-1:0] duty3,
    input  logic [CNT_W-1:0] duty4,
    output logic [NCH-1:0]   pwm,
    output logic             period_end,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             r_period_end;
    logic             w_active;
    logic             w_wrap;
    logic             w_load;
    logic [CNT_W-1:0] w_duty [NCH];

    assign w_active = (r_state != IDLE);
    assign w_wrap   = w_active && (r_cnt == LAST);
    assign w_load   = (r_state == IDLE) || w_wrap;

    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        w_next_state = r_state;
        w_next_cnt   = '0;
        case (r_state)
            IDLE:    if (en) w_next_state = RUN;
            RUN:     if (!en) w_next_state = DRAIN;
            DRAIN: begin
                if (en)
                    w_next_state = RUN;
                else if (r_cnt == LAST)
                    w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
        if (w_active && !w_wrap)
            w_next_cnt = r_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_period_end <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_next_cnt;
            r_period_end <= w_wrap;
        end
    end

    assign w_duty[0] = duty1;
    assign w_duty[1] = duty2;
    assign w_duty[2] = duty3;
    assign w_duty[3] = duty4;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        pwm_channel u_ch (
            .clk      (clk),
            .rst      (rst),
            .i_load   (w_load),
            .i_active (w_active),
            .i_cnt    (r_cnt),
            .i_duty   (w_duty[g]),
            .o_pwm    (pwm[g])
        );
    end

    assign period_end = r_period_end;
    assign busy       = w_active;

endmodule

// File: tb/tb_quad_pwm.sv
// Directed bench for quad_pwm: a PERIOD=9 instance and a PERIOD=1 instance share inputs.
module tb_quad_pwm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [11:0] duty1 = '0, duty2 = '0, duty3 = '0, duty4 = '0;
    logic [3:0]  pwm9, pwm1;
    logic        pe9, pe1, busy9, busy1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    quad_pwm #(.PERIOD(9)) dut9 (
        .clk(clk), .rst(rst), .en(en),
        .duty1(duty1), .duty2(duty2), .duty3(duty3), .duty4(duty4),
        .pwm(pwm9), .period_end(pe9), .busy(busy9)
    );

    quad_pwm #(.PERIOD(1)) dut1 (
        .clk(clk), .rst(rst), .en(en),
        .duty1(duty1), .duty2(duty2), .duty3(duty3), .duty4(duty4),
        .pwm(pwm1), .period_end(pe1), .busy(busy1)
    );

    typedef struct {
        logic [3:0] pwm;
        logic       pe;
        logic       busy;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        tick();
        check("rst_pwm9", 32'(pwm9), 32'h0);
        check("rst_pe9", 32'(pe9), 32'h0);
        check("rst_busy9", 32'(busy9), 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        int hi;
        int pe_cnt;

        // Table: en=1 from reset, duty1=3 duty2=0 duty3=10 duty4=4095; row k-1 is after edge k.
        vecs[0]  = '{4'b0000, 1'b0, 1'b1};
        vecs[1]  = '{4'b1101, 1'b0, 1'b1};
        vecs[2]  = '{4'b1101, 1'b0, 1'b1};
        vecs[3]  = '{4'b1101, 1'b0, 1'b1};
        vecs[4]  = '{4'b1100, 1'b0, 1'b1};
        vecs[5]  = '{4'b1100, 1'b0, 1'b1};
        vecs[6]  = '{4'b1100, 1'b0, 1'b1};
        vecs[7]  = '{4'b1100, 1'b0, 1'b1};
        vecs[8]  = '{4'b1100, 1'b0, 1'b1};
        vecs[9]  = '{4'b1100, 1'b0, 1'b1};
        vecs[10] = '{4'b1100, 1'b1, 1'b1};
        vecs[11] = '{4'b1101, 1'b0, 1'b1};
        vecs[12] = '{4'b1101, 1'b0, 1'b1};

        duty1 = 12'd3; duty2 = 12'd0; duty3 = 12'd10; duty4 = 12'd4095;
        do_reset();
        check("idle_pwm9", 32'(pwm9), 32'h0);
        check("idle_pwm1", 32'(pwm1), 32'h0);
        check("idle_pe1", 32'(pe1), 32'h0);
        en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tick();
            check($sformatf("vec%0d_pwm", i), 32'(pwm9), 32'(vecs[i].pwm));
            check($sformatf("vec%0d_pe", i), 32'(pe9), 32'(vecs[i].pe));
            check($sformatf("vec%0d_busy", i), 32'(busy9), 32'(vecs[i].busy));
        end

        // Duty change mid-period takes effect on the next period.
        duty1 = 12'd3;
        do_reset();
        en = 1'b1;
        tick();
        for (int k = 2; k <= 21; k++) begin
            tick();
            check($sformatf("dchg_e%0d", k), 32'(pwm9[0]),
                  32'(((k - 2) % 10) < ((k < 12) ? 3 : 6)));
            if (k == 5) duty1 = 12'd6;
        end

        // en dropped at cnt==4: drain to the end of the period, one pulse, then idle.
        duty1 = 12'd3;
        do_reset();
        en = 1'b1;
        for (int k = 1; k <= 5; k++) tick();
        en = 1'b0;
        pe_cnt = 0;
        for (int k = 6; k <= 10; k++) begin
            tick();
            if (pe9) pe_cnt++;
        end
        check("drain_busy_e10", 32'(busy9), 32'h1);
        tick();
        check("drain_pe_e11", 32'(pe9), 32'h1);
        check("drain_busy_e11", 32'(busy9), 32'h0);
        tick();
        check("drain_pwm_e12", 32'(pwm9), 32'h0);
        check("drain_pe_e12", 32'(pe9), 32'h0);
        check("drain_early_pulses", 32'(pe_cnt), 32'h0);

        // en re-raised at cnt==9 during DRAIN: the next period starts without a gap.
        do_reset();
        en = 1'b1;
        for (int k = 1; k <= 5; k++) tick();
        en = 1'b0;
        for (int k = 6; k <= 10; k++) tick();
        en = 1'b1;
        tick();
        check("rerun_pe_e11", 32'(pe9), 32'h1);
        check("rerun_busy_e11", 32'(busy9), 32'h1);
        tick();
        check("rerun_pwm_e12", 32'(pwm9[0]), 32'h1);
        check("rerun_busy_e12", 32'(busy9), 32'h1);

        // Asynchronous reset between edges at cnt==5 with duty1=8.
        duty1 = 12'd8;
        do_reset();
        en = 1'b1;
        for (int k = 1; k <= 6; k++) tick();
        check("arst_pre_pwm", 32'(pwm9[0]), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("arst_pwm", 32'(pwm9), 32'h0);
        check("arst_pe", 32'(pe9), 32'h0);
        check("arst_busy", 32'(busy9), 32'h0);
        hi = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (pe9 || pwm9 != 4'b0) hi++;
        end
        check("arst_quiet", 32'(hi), 32'h0);
        rst = 1'b0;
        tick();
        check("arst_after_e1", 32'(pwm9[0]), 32'h0);
        tick();
        check("arst_after_e2", 32'(pwm9[0]), 32'h1);

        // PERIOD=1 instance with duty1=1: pwm alternates, period_end every second cycle.
        duty1 = 12'd1;
        do_reset();
        en = 1'b1;
        tick();
        check("p1_e1_pwm", 32'(pwm1[0]), 32'h0);
        for (int k = 2; k <= 9; k++) begin
            tick();
            check($sformatf("p1_e%0d_pwm", k), 32'(pwm1[0]), 32'((k % 2) == 0));
            check($sformatf("p1_e%0d_pe", k), 32'(pe1), 32'((k % 2) == 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
